// File: rtl/udp_oe_rx_parser.sv
// RX-side UDP offload parser: filters Ethernet/IPv4/UDP frames against the CSRs,
// strips the 42-byte header and realigns the payload to lane 0.
module udp_oe_rx_parser #(
   parameter int unsigned BYTES_PER_WORD   = 8,
   parameter int unsigned CNT_WIDTH        = 32,
   parameter bit          ACCEPT_BROADCAST = 1'b1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [8*BYTES_PER_WORD-1:0]   s_tdata,
   input  logic [BYTES_PER_WORD-1:0]     s_tkeep,
   input  logic                          s_tvalid,
   input  logic                          s_tlast,
   output logic                          s_tready,
   output logic [8*BYTES_PER_WORD-1:0]   m_tdata,
   output logic [BYTES_PER_WORD-1:0]     m_tkeep,
   output logic                          m_tvalid,
   output logic                          m_tlast,
   input  logic                          m_tready,
   output logic [31:0]                   m_src_ip,
   output logic [15:0]                   m_src_port,
   input  logic [47:0]                   csr_fpga_mac,
   input  logic [31:0]                   csr_fpga_ip,
   input  logic [15:0]                   csr_fpga_udp_port,
   input  logic                          cnt_clr,
   output logic [CNT_WIDTH-1:0]          pkt_ok_cnt,
   output logic [CNT_WIDTH-1:0]          pkt_drop_cnt,
   output logic [CNT_WIDTH-1:0]          arp_cnt
);

   localparam int unsigned KEEP_W = BYTES_PER_WORD;

   typedef enum logic [1:0] {ST_HDR, ST_DROP, ST_PAYLOAD, ST_FLUSH} state_t;

   state_t      state;
   logic [2:0]  bcnt;
   logic        rdy_en;
   logic [47:0] dst_mac;
   logic [15:0] etype;
   logic [7:0]  ver_ihl;
   logic [7:0]  proto;
   logic [31:0] src_ip_q;
   logic [31:0] dst_ip;
   logic [15:0] src_port_q;
   logic [15:0] dst_port;
   logic [47:0] res;
   logic [7:0]  flush_keep;

   logic [7:0]  lane [KEEP_W];
   logic        out_free_c;
   logic        acc_c;
   logic        hdr_acc_c;
   logic [15:0] etype_c;
   logic        mac_ok_c;
   logic        pass_c;
   logic        runt_c;
   logic        filt_fail_c;
   logic        is_arp_c;
   logic        drop_inc_c;
   logic        arp_inc_c;

   always_comb begin
      for (int i = 0; i < int'(KEEP_W); i++) lane[i] = s_tdata[8*i +: 8];
   end

   // Beat 5 waits for a free output slot so a pending tlast word keeps its m_src_* intact.
   always_comb begin
      out_free_c = !m_tvalid || m_tready;
      s_tready   = 1'b0;
      if (rdy_en) begin
         case (state)
            ST_HDR:     s_tready = (bcnt == 3'd5) ? out_free_c : 1'b1;
            ST_DROP:    s_tready = 1'b1;
            ST_PAYLOAD: s_tready = out_free_c;
            default:    s_tready = 1'b0;
         endcase
      end
   end

   always_comb begin
      acc_c       = s_tvalid && s_tready;
      hdr_acc_c   = acc_c && (state == ST_HDR);
      etype_c     = (bcnt == 3'd1) ? {lane[4], lane[5]} : etype;
      mac_ok_c    = (dst_mac == csr_fpga_mac) ||
                    (ACCEPT_BROADCAST && (dst_mac == 48'hFFFF_FFFF_FFFF));
      pass_c      = (etype == 16'h0800) && (ver_ihl == 8'h45) && (proto == 8'h11) &&
                    (dst_ip == csr_fpga_ip) && (dst_port == csr_fpga_udp_port) && mac_ok_c;
      runt_c      = s_tlast && ((bcnt != 3'd5) || !s_tkeep[2]);
      filt_fail_c = (bcnt == 3'd5) && !runt_c && !pass_c;
      is_arp_c    = (bcnt != 3'd0) && (etype_c == 16'h0806);
      drop_inc_c  = hdr_acc_c && (runt_c || (filt_fail_c && !is_arp_c));
      arp_inc_c   = hdr_acc_c && is_arp_c && (runt_c || filt_fail_c);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_HDR;
         bcnt         <= 3'd0;
         rdy_en       <= 1'b0;
         dst_mac      <= '0;
         etype        <= '0;
         ver_ihl      <= '0;
         proto        <= '0;
         src_ip_q     <= '0;
         dst_ip       <= '0;
         src_port_q   <= '0;
         dst_port     <= '0;
         res          <= '0;
         flush_keep   <= '0;
         m_tdata      <= '0;
         m_tkeep      <= '0;
         m_tvalid     <= 1'b0;
         m_tlast      <= 1'b0;
         m_src_ip     <= '0;
         m_src_port   <= '0;
         pkt_ok_cnt   <= '0;
         pkt_drop_cnt <= '0;
         arp_cnt      <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (m_tvalid && m_tready) m_tvalid <= 1'b0;

         case (state)
            ST_HDR: begin
               if (acc_c) begin
                  case (bcnt)
                     3'd0: dst_mac <= {lane[0], lane[1], lane[2], lane[3], lane[4], lane[5]};
                     3'd1: begin
                        etype   <= {lane[4], lane[5]};
                        ver_ihl <= lane[6];
                     end
                     3'd2: proto <= lane[7];
                     3'd3: begin
                        src_ip_q     <= {lane[2], lane[3], lane[4], lane[5]};
                        dst_ip[31:16] <= {lane[6], lane[7]};
                     end
                     3'd4: begin
                        dst_ip[15:0] <= {lane[0], lane[1]};
                        src_port_q   <= {lane[2], lane[3]};
                        dst_port     <= {lane[4], lane[5]};
                     end
                     default: ;
                  endcase
                  if (bcnt != 3'd5) begin
                     bcnt <= s_tlast ? 3'd0 : bcnt + 3'd1;
                  end else begin
                     bcnt <= 3'd0;
                     if (runt_c) begin
                        state <= ST_HDR;
                     end else if (pass_c) begin
                        m_src_ip   <= src_ip_q;
                        m_src_port <= src_port_q;
                        res        <= s_tdata[63:16];
                        if (s_tlast) begin
                           m_tvalid <= 1'b1;
                           m_tdata  <= {16'h0, s_tdata[63:16]};
                           m_tkeep  <= {2'b00, s_tkeep[7:2]};
                           m_tlast  <= 1'b1;
                           state    <= ST_HDR;
                        end else begin
                           state <= ST_PAYLOAD;
                        end
                     end else begin
                        state <= s_tlast ? ST_HDR : ST_DROP;
                     end
                  end
               end
            end
            ST_DROP: begin
               if (acc_c && s_tlast) state <= ST_HDR;
            end
            // Output word = 6 residue bytes followed by the first 2 bytes of this beat.
            ST_PAYLOAD: begin
               if (acc_c) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= {s_tdata[15:0], res};
                  res      <= s_tdata[63:16];
                  m_tkeep  <= 8'hFF;
                  m_tlast  <= 1'b0;
                  if (s_tlast) begin
                     if (!s_tkeep[2]) begin
                        m_tkeep <= {s_tkeep[1:0], 6'h3F};
                        m_tlast <= 1'b1;
                        state   <= ST_HDR;
                     end else begin
                        flush_keep <= {2'b00, s_tkeep[7:2]};
                        state      <= ST_FLUSH;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (out_free_c) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= {16'h0, res};
                  m_tkeep  <= flush_keep;
                  m_tlast  <= 1'b1;
                  state    <= ST_HDR;
               end
            end
            default: state <= ST_HDR;
         endcase

         // Clear wins over a same-cycle increment.
         if (cnt_clr) begin
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
            arp_cnt      <= '0;
         end else begin
            if (m_tvalid && m_tready && m_tlast) pkt_ok_cnt <= pkt_ok_cnt + CNT_WIDTH'(1);
            if (drop_inc_c) pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
            if (arp_inc_c)  arp_cnt      <= arp_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule
